// File: rtl/mem_wb_reg_pkg.sv
// Purpose: shared types for the MEM/WB pipeline register (state encoding, entry layout).
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
`include "defines.v"

package mem_wb_reg_pkg;

  localparam int DATA_W = `XLEN;
  localparam int RD_W   = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              wen;
  } entry_t;

  // Writeback value is resolved at capture time so each entry stores one result.
  function automatic entry_t make_entry(
    input logic              mem_read,
    input logic [DATA_W-1:0] load_data,
    input logic [DATA_W-1:0] alu_data,
    input logic [RD_W-1:0]   rd,
    input logic              wen
  );
    entry_t e;
    e.data = mem_read ? load_data : alu_data;
    e.rd   = rd;
    e.wen  = wen;
    return e;
  endfunction

endpackage

// File: rtl/defines.v
`ifndef DEFINES_V
`define DEFINES_V
`define XLEN 64
`endif

// File: rtl/mem_wb_reg_wb_entry.sv
// Purpose: load-enable register holding one writeback entry {data, rd, wen}.
// Latency: 1 cycle from load to q.
// Backpressure: none; holds its value whenever load is low.
// Ports: clk, rst (sync, active-high, clears to zero), load, d -> q.
module wb_entry
  import mem_wb_reg_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  entry_t d,
  output entry_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_reg.sv
// Purpose: MEM->WB pipeline register with a one-deep skid buffer (main + skid entries).
// Latency: 1 cycle from accept to outputs when empty or draining; strict FIFO order.
// Backpressure: in_ready is registered and drops only while both entries are full.
// Ports: clk/rst/flush; MEM side in_valid/in_ready + ex_result_out, m_data, m_mem_read,
//        rd_addr, rd_wen; WB side out_valid/out_ready + wb_data, wb_rd, wb_wen.
module mem_wb_reg
  import mem_wb_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [`XLEN-1:0]  ex_result_out,
  input  logic [`XLEN-1:0]  m_data,
  input  logic              m_mem_read,
  input  logic [RD_W-1:0]   rd_addr,
  input  logic              rd_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [`XLEN-1:0]  wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_wen
);

  state_t state;
  state_t state_nxt;
  entry_t in_entry;
  entry_t main_d;
  entry_t main_q;
  entry_t skid_q;
  logic   main_load;
  logic   skid_load;
  logic   accept;
  logic   consume;

  assign accept    = in_valid & in_ready;
  assign out_valid = (state != ST_EMPTY);
  assign consume   = out_valid & out_ready;
  assign in_entry  = make_entry(m_mem_read, m_data, ex_result_out, rd_addr, rd_wen);

  // Entry load controls. Flush suppresses every load so a same-cycle accept is dropped.
  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_entry;
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_nxt = ST_TWO;
          end else if (consume) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume) begin
            main_load = 1'b1;
            main_d    = skid_q;
            state_nxt = ST_ONE;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // in_ready is computed from the next state and registered, so out_ready has
  // no combinational route to in_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_TWO);
    end
  end

  wb_entry u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  wb_entry u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (in_entry),
    .q    (skid_q)
  );

  assign wb_data = main_q.data;
  assign wb_rd   = main_q.rd;
  // x0 writes flow through as normal entries but never enable the register file.
  assign wb_wen  = out_valid & main_q.wen & (main_q.rd != '0);

endmodule

// File: tb/tb_mem_wb_reg.sv
`include "defines.v"

module tb_mem_wb_reg;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [`XLEN-1:0]  ex_result_out;
  logic [`XLEN-1:0]  m_data;
  logic              m_mem_read;
  logic [4:0]        rd_addr;
  logic              rd_wen;
  logic              out_valid;
  logic              out_ready;
  logic [`XLEN-1:0]  wb_data;
  logic [4:0]        wb_rd;
  logic              wb_wen;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [`XLEN-1:0] data;
    logic [4:0]       rd;
    logic             wen;
  } exp_t;

  typedef struct {
    logic [`XLEN-1:0] ex;
    logic [`XLEN-1:0] md;
    logic             mr;
    logic [4:0]       rd;
    logic             rw;
    logic [`XLEN-1:0] exp_data;
    logic             exp_wen;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];

  always #5 clk = ~clk;

  mem_wb_reg dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ex_result_out (ex_result_out),
    .m_data        (m_data),
    .m_mem_read    (m_mem_read),
    .rd_addr       (rd_addr),
    .rd_wen        (rd_wen),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_wen        (wb_wen)
  );

  task automatic chkw(input string nm, input logic [`XLEN-1:0] act, input logic [`XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [`XLEN-1:0] ex, input logic [`XLEN-1:0] md,
                       input logic mr, input logic [4:0] rd, input logic rw);
    ex_result_out = ex;
    m_data        = md;
    m_mem_read    = mr;
    rd_addr       = rd;
    rd_wen        = rw;
    in_valid      = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    chkw({tag, "_wb_data"}, wb_data, '0);
    chkw({tag, "_wb_rd"}, {{(`XLEN-5){1'b0}}, wb_rd}, '0);
    chk1({tag, "_wb_wen"}, wb_wen, 1'b0);
  endtask

  // Scoreboard: push the modelled entry on accept, pop and compare on consume.
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got entry data %0h rd %0d expected none", wb_data, wb_rd);
        end else begin
          e = sb.pop_front();
          chkw("sb_data", wb_data, e.data);
          chkw("sb_rd", {{(`XLEN-5){1'b0}}, wb_rd}, {{(`XLEN-5){1'b0}}, e.rd});
          chk1("sb_wen", wb_wen, e.wen);
        end
      end
      if (in_valid && in_ready) begin
        e.data = m_mem_read ? m_data : ex_result_out;
        e.rd   = rd_addr;
        e.wen  = rd_wen && (rd_addr != 5'd0);
        sb.push_back(e);
      end
    end
  end

  initial begin
    tbl[0] = '{64'h10, 64'h0, 1'b0, 5'd5, 1'b1, 64'h10, 1'b1};
    tbl[1] = '{64'h2000, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 5'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b1};
    tbl[2] = '{64'h33, 64'h44, 1'b0, 5'd0, 1'b1, 64'h33, 1'b0};
    tbl[3] = '{64'h55, 64'hAA, 1'b1, 5'd31, 1'b0, 64'hAA, 1'b0};
    tbl[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0, 5'd12, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1};
    tbl[5] = '{64'h0, 64'h77, 1'b1, 5'd1, 1'b1, 64'h77, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ex_result_out = '0; m_data = '0; m_mem_read = 1'b0; rd_addr = '0; rd_wen = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("rst");

    // Single transactions: each appears the cycle after acceptance.
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].ex, tbl[i].md, tbl[i].mr, tbl[i].rd, tbl[i].rw);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk1($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
      chkw($sformatf("vec%0d_wb_data", i), wb_data, tbl[i].exp_data);
      chkw($sformatf("vec%0d_wb_rd", i), {{(`XLEN-5){1'b0}}, wb_rd}, {{(`XLEN-5){1'b0}}, tbl[i].rd});
      chk1($sformatf("vec%0d_wb_wen", i), wb_wen, tbl[i].exp_wen);
      chk1($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
      step();
    end

    // Backpressure: fill both entries, hold, then drain in order.
    out_ready = 1'b0;
    drive(64'd1, 64'd0, 1'b0, 5'd1, 1'b1);
    step();
    drive(64'd2, 64'd0, 1'b0, 5'd2, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk1("bp_in_ready_low", in_ready, 1'b0);
    chk1("bp_out_valid", out_valid, 1'b1);
    chkw("bp_hold_a", wb_data, 64'd1);
    step();
    @(negedge clk);
    chkw("bp_hold_a2", wb_data, 64'd1);
    chk1("bp_in_ready_low2", in_ready, 1'b0);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chkw("bp_drain_a", wb_data, 64'd1);
    step();
    @(negedge clk);
    chkw("bp_drain_b", wb_data, 64'd2);
    chk1("bp_in_ready_back", in_ready, 1'b1);
    step();
    @(negedge clk);
    chk1("bp_empty", out_valid, 1'b0);

    // Flush while full, then flush racing an accept from empty.
    step();
    out_ready = 1'b0;
    drive(64'd3, 64'd0, 1'b0, 5'd3, 1'b1);
    step();
    drive(64'd4, 64'd0, 1'b0, 5'd4, 1'b1);
    step();
    drive(64'd5, 64'd0, 1'b0, 5'd5, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk1("fl_out_valid", out_valid, 1'b0);
    chk1("fl_in_ready", in_ready, 1'b1);
    step();
    drive(64'd6, 64'd0, 1'b0, 5'd6, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk1("fl_accept_dropped", out_valid, 1'b0);
    step();
    out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk1("fl_nothing_later", out_valid, 1'b0);

    // Streaming: 16 back-to-back entries with in_ready never dropping.
    step();
    for (int v = 1; v <= 16; v++) begin
      drive(64'(v), 64'hDEAD, 1'b0, 5'(v), 1'b1);
      @(negedge clk);
      chk1($sformatf("stream_in_ready%0d", v), in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL stream_drained: got %0d pending expected 0", sb.size());
    end

    // Mid-operation reset (with flush and in_valid also high) drops everything.
    out_ready = 1'b0;
    drive(64'd7, 64'd0, 1'b0, 5'd7, 1'b1);
    step();
    drive(64'd8, 64'd0, 1'b0, 5'd8, 1'b1);
    step();
    drive(64'd9, 64'd0, 1'b0, 5'd9, 1'b1);
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk_reset_state("midrst");
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk1("midrst_no_entry", out_valid, 1'b0);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_final_empty: got %0d pending expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_reg.md
MEM_WB_REG -- requirements
Module: mem_wb_reg

Interface
REQ-001 Width macro: `XLEN, default 64, datapath width, taken from defines.v; block SHALL NOT define its own.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  discard all buffered entries (trap/redirect).
REQ-005 in_valid  input  1  MEM stage presents an instruction.
REQ-006 in_ready  output  1  block accepts this cycle; SHALL be a register output.
REQ-007 ex_result_out  input  `XLEN  ALU result/address passed through MEM.
REQ-008 m_data  input  `XLEN  load data from dcache, already extended per m_mem_mode.
REQ-009 m_mem_read  input  1  instruction is a load.
REQ-010 rd_addr  input  5  destination register.
REQ-011 rd_wen  input  1  instruction writes rd.
REQ-012 out_valid  output  1  WB entry valid.
REQ-013 out_ready  input  1  writeback consumes the entry.
REQ-014 wb_data  output  `XLEN  selected writeback value.
REQ-015 wb_rd  output  5  writeback destination.
REQ-016 wb_wen  output  1  register-file write enable, equal to out_valid & stored rd_wen & (wb_rd != 0).

Function
REQ-017 Accept when in_valid & in_ready; consume when out_valid & out_ready.
REQ-018 Capture-time select: data = m_mem_read ? m_data : ex_result_out; one result register per entry, not two.
REQ-019 Storage: main entry (drives outputs) plus one skid entry.
REQ-020 States: EMPTY (none), ONE (main only), TWO (main + skid).
REQ-021 EMPTY: accept -> ONE, load main.
REQ-022 ONE, accept with no consume -> TWO, load skid.
REQ-023 ONE, consume with no accept -> EMPTY.
REQ-024 ONE, accept and consume together -> ONE, main reloaded from input.
REQ-025 TWO: in_ready=0; consume -> ONE, skid moves to main; no consume -> hold.
REQ-026 in_ready next = 0 iff next state is TWO.
REQ-027 Latency: accepted entry appears on outputs the cycle after acceptance when EMPTY, or ONE with a consume.
REQ-028 Order: strict FIFO, no reordering or duplication.
REQ-029 flush: next state EMPTY, in_ready=1, and any same-cycle accept dropped; flush outranks accept and consume.
REQ-030 Outputs SHALL hold stable while out_valid & !out_ready.
REQ-031 Writes to rd=0 SHALL propagate with wb_wen=0 and count as normal entries.

Reset
REQ-032 On rst: state EMPTY, out_valid=0, in_ready=1, wb_data=0, wb_rd=0, wb_wen=0, skid cleared.
REQ-033 rst outranks flush and all handshakes; mid-operation reset drops all entries.

Structure
REQ-034 State encoding (EMPTY/ONE/TWO) and entry field widths SHALL go in the shared defines package.
REQ-035 One sub-module is natural: wb_entry, a load-enable register holding {data, rd, wen}, instantiated twice (main, skid).
REQ-036 Target size is 120-400 RTL lines, with no combinational path from out_ready to in_ready.

Verification
REQ-037 After reset, in_valid=1, rd=5, ex_result_out=0x10, load=0, out_ready=1 -> next cycle out_valid=1, wb_data=0x10, wb_rd=5, wb_wen=1.
REQ-038 Load: m_mem_read=1, m_data=0xFFFF_FFFF_FFFF_FF80, ex_result_out=0x2000 -> wb_data=0xFFFF_FFFF_FFFF_FF80.
REQ-039 With out_ready=0, push A=1 then B=2 -> in_ready=0 after B and outputs hold A; raise out_ready -> A, then B on consecutive cycles; in_ready returns to 1.
REQ-040 In TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry emerges later.
REQ-041 rd_addr=0, rd_wen=1 -> out_valid=1, wb_wen=0.
REQ-042 Continuous in_valid and out_ready for 16 cycles, values 1..16 -> outputs 1..16 in order, in_ready never low.
